seg_display_driver: RTL

//  Consumer end of the calculator's 8-bit result bus. Latches a result byte on a

---
 rtl/disp_pkg.sv | 34 +++
 rtl/hex_to_seg.sv | 13 +
 rtl/seg_display_driver.sv | 103 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment result display.
//   disp_state_t : display sequencing states
//   SEG_BLANK    : all segments off
//   GLYPHS       : hex digit -> {g,f,e,d,c,b,a} segment pattern, active-high
//   next_phase() : successor of a state in the looping digit/gap sequence
package disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_HI,
    GAP_HI,
    SHOW_LO,
    GAP_LO
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // IDLE is only left through a load, so it maps to itself here.
  function automatic disp_state_t next_phase(input disp_state_t s);
    case (s)
      SHOW_HI: next_phase = GAP_HI;
      GAP_HI:  next_phase = SHOW_LO;
      SHOW_LO: next_phase = GAP_LO;
      GAP_LO:  next_phase = SHOW_HI;
      default: next_phase = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to 7-segment glyph decoder.
//   nibble : in  4 - hex digit 0..F
//   glyph  : out 7 - segments {g,f,e,d,c,b,a}, active-high
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// Latches a result byte and time-multiplexes it as two hex digits (high nibble,
// then low nibble) on one 7-segment display, blanking between digits.
//   clk        : in  1 - clock, all state on posedge
//   Reset      : in  1 - synchronous reset, active-high (wins over everything)
//   ena        : in  1 - 0 blanks the display and freezes the sequence
//   value      : in  8 - result byte
//   value_load : in  1 - capture value and restart at the high digit
//   seg        : out 7 - segments {g,f,e,d,c,b,a}, registered
//   dp         : out 1 - decimal point, registered
//   busy       : out 1 - a value has been loaded since reset
// Configuration: define DISP_DP_MARK_EN to light dp while the low digit is shown;
// otherwise dp stays 0.
module seg_display_driver
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES   = 2_500_000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ena,
  input  logic [7:0] value,
  input  logic       value_load,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  disp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       held_q, held_d;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             showing_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    if (value_load) begin
      // A load is always accepted and aborts whatever digit/gap is in progress.
      held_d  = value;
      state_d = SHOW_HI;
      cnt_d   = '0;
    end else if (ena && state_q != IDLE) begin
      if (cnt_q == (((state_q == SHOW_HI) || (state_q == SHOW_LO)) ? DIGIT_LAST : GAP_LAST)) begin
        cnt_d   = '0;
        state_d = next_phase(state_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Segments are decoded from the next state so the register lines up with the
  // state it describes: a load shows the high digit on the very next cycle.
  assign nibble    = (state_d == SHOW_LO) ? held_d[3:0] : held_d[7:4];
  assign showing_d = (state_d == SHOW_HI) || (state_d == SHOW_LO);

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    seg_d = (ena && showing_d) ? glyph : SEG_BLANK;
`ifdef DISP_DP_MARK_EN
    dp_d  = ena && (state_d == SHOW_LO);
`else
    dp_d  = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 8'h00;
      seg     <= SEG_BLANK;
      dp      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      seg     <= seg_d;
      dp      <= dp_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
